// File: rtl/jesd_rx_pkg.sv
// Shared types and constants for the JESD204B RX lane front-end.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents:
//   align_state_e  octet aligner search/lock states
//   K28_5          comma character seen during code group synchronisation
package jesd_rx_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        CGS    = 2'd1,
        LOCKED = 2'd2
    } align_state_e;

    localparam logic [7:0] K28_5 = 8'hBC;

endpackage

// File: rtl/octet_first_nonk.sv
// Priority encoder: index of the lowest octet whose K28 flag is clear, plus an all-K flag.
// Latency: combinational, 0 cycles.
// Backpressure: none; pure function of the flags.
//
// Ports:
//   k28_i   in   N            per-octet K28 flags, octet 0 oldest
//   idx_o   out  $clog2(N)    lowest index with flag clear (0 when all flags set)
//   allk_o  out  1            every octet is K28
module octet_first_nonk #(
    parameter int N = 4
) (
    input  logic [N-1:0]         k28_i,
    output logic [$clog2(N)-1:0] idx_o,
    output logic                 allk_o
);

    localparam int IW = $clog2(N);

    // Scan from the top down so the lowest clear flag is the last to write.
    always_comb begin
        idx_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (!k28_i[i]) begin
                idx_o = IW'(i);
            end
        end
    end

    assign allk_o = &k28_i;

endmodule

// File: rtl/octet_align_auto.sv
// Octet aligner: finds the CGS->ILAS boundary, locks the octet offset and emits frame-aligned words.
// Latency: 1 clk from an input beat to its aligned output beat (the lock beat itself is not emitted).
// Backpressure: none; in_valid_i=0 freezes all state, out_valid_o follows valid beats while locked.
//
// Ports:
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   in_valid_i          input beat qualifier
//   in_data_i           decoded word, octet 0 = bits [7:0] (oldest on the line)
//   in_char_is_k28_i    per-octet K28 flags
//   realign_i           drop lock and restart the search
//   out_valid_o         aligned beat qualifier
//   out_data_o          aligned word
//   out_char_is_k28_o   aligned K28 flags
//   aligned_o           high while locked
//   offset_o            locked octet offset
module octet_align_auto
    import jesd_rx_pkg::*;
#(
    parameter int PARALLEL_OCTETS = 4,
    parameter int DATA_WIDTH      = PARALLEL_OCTETS * 8,
    parameter int CGS_MIN_WORDS   = 4
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               in_valid_i,
    input  logic [DATA_WIDTH-1:0]              in_data_i,
    input  logic [PARALLEL_OCTETS-1:0]         in_char_is_k28_i,
    input  logic                               realign_i,
    output logic                               out_valid_o,
    output logic [DATA_WIDTH-1:0]              out_data_o,
    output logic [PARALLEL_OCTETS-1:0]         out_char_is_k28_o,
    output logic                               aligned_o,
    output logic [$clog2(PARALLEL_OCTETS)-1:0] offset_o
);

    localparam int OW = $clog2(PARALLEL_OCTETS);
    localparam int CW = $clog2(CGS_MIN_WORDS + 1);
    localparam logic [CW-1:0] CNT_MIN = CW'(CGS_MIN_WORDS);

    align_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [OW-1:0] offset_q, offset_d;

    logic [DATA_WIDTH-1:0]      prev_data_q;
    logic [PARALLEL_OCTETS-1:0] prev_k_q;

    logic                       out_vld_q;
    logic [DATA_WIDTH-1:0]      out_dat_q;
    logic [PARALLEL_OCTETS-1:0] out_k_q;

    logic [OW-1:0] first_nonk;
    logic          allk;

    octet_first_nonk #(
        .N (PARALLEL_OCTETS)
    ) u_first_nonk (
        .k28_i  (in_char_is_k28_i),
        .idx_o  (first_nonk),
        .allk_o (allk)
    );

    // Two-word window: the previous word supplies the older octets, so an
    // offset of 0 selects the previous word exactly and never wraps.
    logic [2*DATA_WIDTH-1:0]      window_dat;
    logic [2*PARALLEL_OCTETS-1:0] window_k;
    logic [DATA_WIDTH-1:0]        slice_dat;
    logic [PARALLEL_OCTETS-1:0]   slice_k;

    assign window_dat = {in_data_i, prev_data_q};
    assign window_k   = {in_char_is_k28_i, prev_k_q};
    assign slice_dat  = window_dat[int'(offset_q) * 8 +: DATA_WIDTH];
    assign slice_k    = window_k[int'(offset_q) +: PARALLEL_OCTETS];

    // Next-state logic. realign_i overrides everything, including a lock
    // that would otherwise happen on the same beat.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        offset_d = offset_q;
        if (realign_i) begin
            state_d  = SEARCH;
            cnt_d    = '0;
            offset_d = '0;
        end else if (in_valid_i) begin
            unique case (state_q)
                SEARCH: begin
                    if (allk) begin
                        cnt_d   = CW'(1);
                        state_d = CGS;
                    end
                end
                CGS: begin
                    if (allk) begin
                        if (cnt_q < CNT_MIN) begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end else if (cnt_q >= CNT_MIN) begin
                        offset_d = first_nonk;
                        cnt_d    = '0;
                        state_d  = LOCKED;
                    end else begin
                        cnt_d   = '0;
                        state_d = SEARCH;
                    end
                end
                LOCKED: begin
                    // Payload is not monitored once locked.
                end
                default: begin
                    state_d = SEARCH;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= SEARCH;
            cnt_q    <= '0;
            offset_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            offset_q <= offset_d;
        end
    end

    // Previous word tracks every valid beat so the window is already
    // populated on the beat after lock.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_data_q <= '0;
            prev_k_q    <= '0;
        end else if (in_valid_i) begin
            prev_data_q <= in_data_i;
            prev_k_q    <= in_char_is_k28_i;
        end
    end

    // Output register. Gated on the pre-edge state, so the lock beat is not
    // emitted and the first output starts at the boundary octet.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_vld_q <= 1'b0;
            out_dat_q <= '0;
            out_k_q   <= '0;
        end else if (in_valid_i && (state_q == LOCKED) && !realign_i) begin
            out_vld_q <= 1'b1;
            out_dat_q <= slice_dat;
            out_k_q   <= slice_k;
        end else begin
            out_vld_q <= 1'b0;
        end
    end

    assign out_valid_o       = out_vld_q;
    assign out_data_o        = out_dat_q;
    assign out_char_is_k28_o = out_k_q;
    assign aligned_o         = (state_q == LOCKED);
    assign offset_o          = offset_q;

endmodule

// File: tb/tb_octet_align_auto.sv
// Bench for octet_align_auto (4 octets, CGS_MIN_WORDS=4).
// Latency: expected values are checked 1 clk after each driven beat.
// Backpressure: none; the bench drives one beat per cycle.
module tb_octet_align_auto;
    import jesd_rx_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        in_valid_i = 1'b0;
    logic [31:0] in_data_i = '0;
    logic [3:0]  in_char_is_k28_i = '0;
    logic        realign_i = 1'b0;
    logic        out_valid_o;
    logic [31:0] out_data_o;
    logic [3:0]  out_char_is_k28_o;
    logic        aligned_o;
    logic [1:0]  offset_o;

    octet_align_auto #(
        .PARALLEL_OCTETS (4),
        .CGS_MIN_WORDS   (4)
    ) dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .in_valid_i        (in_valid_i),
        .in_data_i         (in_data_i),
        .in_char_is_k28_i  (in_char_is_k28_i),
        .realign_i         (realign_i),
        .out_valid_o       (out_valid_o),
        .out_data_o        (out_data_o),
        .out_char_is_k28_o (out_char_is_k28_o),
        .aligned_o         (aligned_o),
        .offset_o          (offset_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic [3:0]  k;
        logic        ra;
        logic        ev;
        logic [31:0] ed;
        logic [3:0]  ek;
        logic        ea;
        logic [1:0]  eo;
        string       name;
    } vec_t;

    vec_t tab1[$];
    vec_t tab2[$];
    vec_t sb[$];

    int checks = 0;
    int errors = 0;

    logic [31:0] kw;
    localparam logic [3:0] KA = 4'b1111;

    function automatic vec_t mk(input logic v, input logic [31:0] d, input logic [3:0] k,
                                input logic ra, input logic ev, input logic [31:0] ed,
                                input logic [3:0] ek, input logic ea, input logic [1:0] eo,
                                input string name);
        vec_t r;
        r.v = v; r.d = d; r.k = k; r.ra = ra;
        r.ev = ev; r.ed = ed; r.ek = ek; r.ea = ea; r.eo = eo; r.name = name;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Drive one beat, queue its expectation, then compare after the edge.
    task automatic apply(input vec_t t);
        vec_t e;
        @(negedge clk_i);
        in_valid_i       = t.v;
        in_data_i        = t.d;
        in_char_is_k28_i = t.k;
        realign_i        = t.ra;
        sb.push_back(t);
        @(posedge clk_i);
        #1;
        e = sb.pop_front();
        check({e.name, ".vld"}, {31'd0, out_valid_o}, {31'd0, e.ev});
        check({e.name, ".aligned"}, {31'd0, aligned_o}, {31'd0, e.ea});
        check({e.name, ".offset"}, {30'd0, offset_o}, {30'd0, e.eo});
        if (e.ev) begin
            check({e.name, ".data"}, out_data_o, e.ed);
            check({e.name, ".k"}, {28'd0, out_char_is_k28_o}, {28'd0, e.ek});
        end
    endtask

    initial begin
        kw = {4{K28_5}};

        // Lock at offset 2, gap while locked, realign while locked,
        // then CGS with a gap and lock at offset 0.
        tab1.push_back(mk(1, kw, KA, 0, 0, 0, 0, 0, 0, "cgs1"));
        tab1.push_back(mk(1, kw, KA, 0, 0, 0, 0, 0, 0, "cgs2"));
        tab1.push_back(mk(1, kw, KA, 0, 0, 0, 0, 0, 0, "cgs3"));
        tab1.push_back(mk(1, kw, KA, 0, 0, 0, 0, 0, 0, "cgs4"));
        tab1.push_back(mk(1, 32'hDDCC_BCBC, 4'b0011, 0, 0, 0, 0, 1, 2, "lock_off2"));
        tab1.push_back(mk(1, 32'h4433_2211, 4'b0000, 0, 1, 32'h2211_DDCC, 4'b0000, 1, 2, "first_out"));
        tab1.push_back(mk(0, 32'hFFFF_FFFF, 4'b0000, 0, 0, 0, 0, 1, 2, "gap_locked"));
        tab1.push_back(mk(1, 32'h8877_6655, 4'b0000, 0, 1, 32'h6655_4433, 4'b0000, 1, 2, "after_gap"));
        tab1.push_back(mk(1, 32'h1234_5678, 4'b0000, 1, 0, 0, 0, 0, 0, "realign_locked"));
        tab1.push_back(mk(1, kw, KA, 0, 0, 0, 0, 0, 0, "b_cgs1"));
        tab1.push_back(mk(0, 32'h0000_0000, 4'b0000, 0, 0, 0, 0, 0, 0, "b_gap"));
        tab1.push_back(mk(1, kw, KA, 0, 0, 0, 0, 0, 0, "b_cgs2"));
        tab1.push_back(mk(1, kw, KA, 0, 0, 0, 0, 0, 0, "b_cgs3"));
        tab1.push_back(mk(1, kw, KA, 0, 0, 0, 0, 0, 0, "b_cgs4"));
        tab1.push_back(mk(1, 32'h1234_5678, 4'b0000, 0, 0, 0, 0, 1, 0, "lock_off0"));
        tab1.push_back(mk(1, 32'h9ABC_DEF0, 4'b0000, 0, 1, 32'h1234_5678, 4'b0000, 1, 0, "off0_out"));

        // After reset: short CGS fails, full CGS locks at offset 3, then a
        // realign on the boundary beat blocks the lock and forces a fresh CGS.
        tab2.push_back(mk(1, kw, KA, 0, 0, 0, 0, 0, 0, "s_cgs1"));
        tab2.push_back(mk(1, kw, KA, 0, 0, 0, 0, 0, 0, "s_cgs2"));
        tab2.push_back(mk(1, kw, KA, 0, 0, 0, 0, 0, 0, "s_cgs3"));
        tab2.push_back(mk(1, 32'h1111_1111, 4'b0000, 0, 0, 0, 0, 0, 0, "short_cgs"));
        tab2.push_back(mk(1, kw, KA, 0, 0, 0, 0, 0, 0, "c_cgs1"));
        tab2.push_back(mk(1, kw, KA, 0, 0, 0, 0, 0, 0, "c_cgs2"));
        tab2.push_back(mk(1, kw, KA, 0, 0, 0, 0, 0, 0, "c_cgs3"));
        tab2.push_back(mk(1, kw, KA, 0, 0, 0, 0, 0, 0, "c_cgs4"));
        tab2.push_back(mk(1, 32'hAABB_CCDD, 4'b0111, 0, 0, 0, 0, 1, 3, "lock_off3"));
        tab2.push_back(mk(1, 32'h1122_3344, 4'b0001, 0, 1, 32'h2233_44AA, 4'b0010, 1, 3, "off3_out"));
        tab2.push_back(mk(1, 32'h0, 4'b0000, 1, 0, 0, 0, 0, 0, "realign2"));
        tab2.push_back(mk(1, kw, KA, 0, 0, 0, 0, 0, 0, "r_cgs1"));
        tab2.push_back(mk(1, kw, KA, 0, 0, 0, 0, 0, 0, "r_cgs2"));
        tab2.push_back(mk(1, kw, KA, 0, 0, 0, 0, 0, 0, "r_cgs3"));
        tab2.push_back(mk(1, kw, KA, 0, 0, 0, 0, 0, 0, "r_cgs4"));
        tab2.push_back(mk(1, 32'hDEAD_BEEF, 4'b0000, 1, 0, 0, 0, 0, 0, "realign_boundary"));
        tab2.push_back(mk(1, kw, KA, 0, 0, 0, 0, 0, 0, "t_cgs1"));
        tab2.push_back(mk(1, kw, KA, 0, 0, 0, 0, 0, 0, "t_cgs2"));
        tab2.push_back(mk(1, kw, KA, 0, 0, 0, 0, 0, 0, "t_cgs3"));
        tab2.push_back(mk(1, 32'h5555_5555, 4'b0000, 0, 0, 0, 0, 0, 0, "t_short"));
        tab2.push_back(mk(1, kw, KA, 0, 0, 0, 0, 0, 0, "u_cgs1"));
        tab2.push_back(mk(1, kw, KA, 0, 0, 0, 0, 0, 0, "u_cgs2"));
        tab2.push_back(mk(1, kw, KA, 0, 0, 0, 0, 0, 0, "u_cgs3"));
        tab2.push_back(mk(1, kw, KA, 0, 0, 0, 0, 0, 0, "u_cgs4"));
        tab2.push_back(mk(1, 32'h0D0C_0B0A, 4'b0001, 0, 0, 0, 0, 1, 1, "lock_off1"));
        tab2.push_back(mk(1, 32'h0403_0201, 4'b0000, 0, 1, 32'h010D_0C0B, 4'b0000, 1, 1, "off1_out"));

        // Reset state.
        repeat (2) @(posedge clk_i);
        #1;
        check("rst.vld", {31'd0, out_valid_o}, 32'd0);
        check("rst.data", out_data_o, 32'd0);
        check("rst.k", {28'd0, out_char_is_k28_o}, 32'd0);
        check("rst.aligned", {31'd0, aligned_o}, 32'd0);
        check("rst.offset", {30'd0, offset_o}, 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        for (int i = 0; i < tab1.size(); i++) begin
            apply(tab1[i]);
        end

        // Asynchronous reset while locked with output valid.
        check("pre_rst.aligned", {31'd0, aligned_o}, 32'd1);
        #2;
        rst_ni = 1'b0;
        #1;
        check("arst.vld", {31'd0, out_valid_o}, 32'd0);
        check("arst.data", out_data_o, 32'd0);
        check("arst.k", {28'd0, out_char_is_k28_o}, 32'd0);
        check("arst.aligned", {31'd0, aligned_o}, 32'd0);
        check("arst.offset", {30'd0, offset_o}, 32'd0);
        in_valid_i = 1'b0;
        realign_i  = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;

        for (int i = 0; i < tab2.size(); i++) begin
            apply(tab2[i]);
        end

        // Output data holds while out_valid_o is low.
        apply(mk(0, 32'h0, 4'b0000, 0, 0, 0, 0, 1, 1, "hold"));
        check("hold.data", out_data_o, 32'h010D_0C0B);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
